// File: rtl/branch_predictor.sv
// branch_predictor: per-PC 2-bit saturating counter BHT with perf counters; define BRANCH_PREDICTOR_GSHARE_EN for GHR-hashed indexing
module branch_predictor #(
  parameter int IDX_BITS = 4,
  parameter int HIST_BITS = 4,
  parameter logic [1:0] INIT_STATE = 2'b10
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [31:0]         lookup_pc_i,
  output logic                predict_o,
  output logic [IDX_BITS-1:0] predict_idx_o,
  input  logic                upd_valid_i,
  input  logic [IDX_BITS-1:0] upd_idx_i,
  input  logic                upd_taken_i,
  input  logic                upd_predict_i,
  output logic                mispredict_o,
  output logic [31:0]         branch_cnt_o,
  output logic [31:0]         mispredict_cnt_o
);
  localparam int N = 1 << IDX_BITS;
  logic [1:0] tbl_q [N];
  logic [1:0] cnt_q, cnt_d;
  logic [31:0] branch_cnt_q, branch_cnt_d, mispredict_cnt_q, mispredict_cnt_d;
  logic [IDX_BITS-1:0] base_idx;
  logic unused_pc;
  assign base_idx = lookup_pc_i[IDX_BITS+1:2];
  assign unused_pc = ^{lookup_pc_i[31:IDX_BITS+2], lookup_pc_i[1:0]};
`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [HIST_BITS-1:0] ghr_q, ghr_d;
  assign predict_idx_o = base_idx ^ IDX_BITS'(ghr_q);
  assign ghr_d = upd_valid_i ? HIST_BITS'({ghr_q, upd_taken_i}) : ghr_q;
  // global history shifts in each resolved outcome
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) ghr_q <= '0;
    else ghr_q <= ghr_d;
`else
  localparam int unused_hist = HIST_BITS;
  assign predict_idx_o = base_idx;
`endif
  assign predict_o = tbl_q[predict_idx_o][1];
  assign mispredict_o = upd_valid_i & (upd_taken_i != upd_predict_i);
  assign branch_cnt_o = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;
  // saturating step of the entry being trained and of both perf counters
  always_comb begin
    cnt_q = tbl_q[upd_idx_i];
    cnt_d = upd_taken_i ? ((&cnt_q) ? cnt_q : cnt_q + 2'd1) : ((|cnt_q) ? cnt_q - 2'd1 : cnt_q);
    branch_cnt_d = (upd_valid_i && !(&branch_cnt_q)) ? branch_cnt_q + 32'd1 : branch_cnt_q;
    mispredict_cnt_d = (mispredict_o && !(&mispredict_cnt_q)) ? mispredict_cnt_q + 32'd1 : mispredict_cnt_q;
  end
  // table trains only the entry named by upd_idx_i; no write-to-read bypass
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      for (int i = 0; i < N; i++) tbl_q[i] <= INIT_STATE;
    end else if (upd_valid_i) begin
      tbl_q[upd_idx_i] <= cnt_d;
    end
  // performance counters
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      branch_cnt_q <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
endmodule
